// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO dequeue adapter.
package fifo_pkg;

  // Data width of the upstream FIFO and of the adapter by default.
  localparam int DEFAULT_WIDTH = 64;

  // Smallest legal number of local buffer entries.
  localparam int MIN_BUF_DEPTH = 2;

  // Width of the optional statistics counters.
  localparam int STATS_W = 32;

  // Occupancy must be able to hold every value 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage : fifo_pkg

// File: rtl/fifo_deq_adapter.sv
// fifo_deq_adapter: turns the dequeue side of a FIFO whose data arrives one
// cycle after the handshake into a plain valid/ready stream. A small local
// buffer absorbs the word still in flight, so in_ready can be computed from
// registered state only.
// Optional feature macro: FIFO_DEQ_ADAPTER_STATS_EN adds beat_count and
// stall_count outputs.
module fifo_deq_adapter
  import fifo_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int BUF_DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef FIFO_DEQ_ADAPTER_STATS_EN
  ,
  output logic [STATS_W-1:0] beat_count,
  output logic [STATS_W-1:0] stall_count
`endif
);

  localparam int OCC_W = occ_width(BUF_DEPTH);
  localparam int PTR_W = $clog2(BUF_DEPTH);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [OCC_W-1:0] occ_t;

  localparam ptr_t LAST_PTR  = ptr_t'(BUF_DEPTH - 1);
  localparam occ_t OCC_ONE   = occ_t'(1);
  localparam logic [OCC_W:0] DEPTH_EXT = (OCC_W + 1)'(BUF_DEPTH);

  // Pointer increment with explicit wrap, correct for non-power-of-2 depths.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  logic [WIDTH-1:0] mem [BUF_DEPTH];

  ptr_t wr_ptr_q;
  ptr_t rd_ptr_q;
  occ_t occ_q;
  logic inflight_q;

  logic           in_hs;
  logic           capture;
  logic           pop;
  logic [OCC_W:0] committed;

  // Handshake and capture/pop qualifiers.
  always_comb begin
    in_hs   = in_valid && in_ready;
    capture = inflight_q;
    pop     = out_valid && out_ready;
  end

  // Words already in the buffer plus the one still arriving; one bit wider so
  // occ_q == BUF_DEPTH plus an inflight word cannot wrap.
  always_comb begin
    committed = {1'b0, occ_q} + {{OCC_W{1'b0}}, inflight_q};
    in_ready  = committed < DEPTH_EXT;
  end

  // Downstream view of the buffer head.
  always_comb begin
    out_valid = (occ_q != '0);
    out_data  = mem[rd_ptr_q];
  end

  // Track the word whose data arrives on in_data one cycle after its handshake.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, matching real hardware ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= in_hs;
    end
  end

  // Write pointer advances on each capture of an in-flight word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
    end else if (capture) begin
      wr_ptr_q <= ptr_inc(wr_ptr_q);
    end
  end

  // Read pointer advances on each downstream handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
    end else if (pop) begin
      rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  // Occupancy: capture and pop together leave it unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q <= '0;
    end else begin
      unique case ({capture, pop})
        2'b10:   occ_q <= occ_q + OCC_ONE;
        2'b01:   occ_q <= occ_q - OCC_ONE;
        default: occ_q <= occ_q;
      endcase
    end
  end

  // Buffer storage: the in-flight word lands at the write pointer.
  // NOTE: the data array has no reset; occupancy gates out_valid, so stale
  // contents are never observed and the array can map to plain RAM/flops.
  always_ff @(posedge clk) begin
    if (capture) begin
      mem[wr_ptr_q] <= in_data;
    end
  end

`ifdef FIFO_DEQ_ADAPTER_STATS_EN
  localparam logic [STATS_W-1:0] STATS_MAX = '1;

  // Saturating count of downstream handshakes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_count <= '0;
    end else if (pop && (beat_count != STATS_MAX)) begin
      beat_count <= beat_count + 1'b1;
    end
  end

  // Saturating count of cycles where valid data is held back by downstream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
    end else if (out_valid && !out_ready && (stall_count != STATS_MAX)) begin
      stall_count <= stall_count + 1'b1;
    end
  end
`endif

endmodule : fifo_deq_adapter
